// File: rtl/tricol_pkg.sv
// Shared colour/state encoding for the tri-colour LED path.
// The sequencer state encoding equals the colour code driven to the LED decoder.
package tricol_pkg;

    localparam int unsigned COL_W = 2;

    typedef enum logic [COL_W-1:0] {
        COL_OFF    = 2'b00,
        COL_RED    = 2'b01,
        COL_GREEN  = 2'b10,
        COL_YELLOW = 2'b11
    } col_t;

    // Colour that follows a running phase: RED -> GREEN -> YELLOW -> RED.
    function automatic col_t next_col(input col_t c);
        case (c)
            COL_RED:    next_col = COL_GREEN;
            COL_GREEN:  next_col = COL_YELLOW;
            default:    next_col = COL_RED;
        endcase
    endfunction

endpackage

// File: rtl/tricol_seq_tick_div.sv
// tick_div: prescaler producing a one-cycle tick every DIV enabled cycles.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   en   - count enable
//   clr  - clear count to 0 (wins over en)
//   tick - high while enabled and the count sits at DIV-1
module tick_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // Tick is gated by en so a frozen count never re-fires.
    assign tick = en && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/tricol_seq.sv
// tricol_seq: timed RED/GREEN/YELLOW sequencer with auto and manual stepping.
// Ports:
//   clk        - clock
//   rst        - synchronous active-high reset
//   ien        - start/stop/step request, rising edge acts
//   mode       - 0 auto cycle, 1 manual step
//   hold       - freeze time base and remain
//   col        - colour code (registered copy of state)
//   remain     - ticks left in current phase minus 1, 0 in IDLE
//   phase_done - one-cycle strobe in the first cycle of a new colour
module tricol_seq
    import tricol_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned T_RED    = 5,
    parameter int unsigned T_GREEN  = 5,
    parameter int unsigned T_YELLOW = 2,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ien,
    input  logic             mode,
    input  logic             hold,
    output logic [1:0]       col,
    output logic [CNT_W-1:0] remain,
    output logic             phase_done
);

    localparam logic [CNT_W-1:0] LEN_RED    = CNT_W'(T_RED - 1);
    localparam logic [CNT_W-1:0] LEN_GREEN  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] LEN_YELLOW = CNT_W'(T_YELLOW - 1);

    // Elaboration-time range checks on phase lengths and divider.
    if (T_RED < 1 || T_RED > 2**CNT_W) begin : g_bad_red
        $error("tricol_seq: T_RED out of range");
    end
    if (T_GREEN < 1 || T_GREEN > 2**CNT_W) begin : g_bad_green
        $error("tricol_seq: T_GREEN out of range");
    end
    if (T_YELLOW < 1 || T_YELLOW > 2**CNT_W) begin : g_bad_yellow
        $error("tricol_seq: T_YELLOW out of range");
    end
    if (TICK_DIV < 2) begin : g_bad_div
        $error("tricol_seq: TICK_DIV must be >= 2");
    end

    col_t             state, state_n;
    logic [CNT_W-1:0] remain_n;
    logic             ien_d;
    logic             ien_e;
    logic             tick;
    logic             tick_en;
    logic             tick_clr;

    // Load value (length-1) for the phase being entered.
    function automatic logic [CNT_W-1:0] load_of(input col_t c);
        case (c)
            COL_RED:    load_of = LEN_RED;
            COL_GREEN:  load_of = LEN_GREEN;
            COL_YELLOW: load_of = LEN_YELLOW;
            default:    load_of = '0;
        endcase
    endfunction

    assign ien_e   = ien & ~ien_d;
    assign tick_en = (state != COL_OFF) && !hold;

    tick_div #(.DIV(TICK_DIV)) u_tick_div (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .clr  (tick_clr),
        .tick (tick)
    );

    // State, remain, strobe and edge-detect registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= COL_OFF;
            remain     <= '0;
            phase_done <= 1'b0;
            ien_d      <= 1'b0;
        end else begin
            state      <= state_n;
            remain     <= remain_n;
            phase_done <= (state_n != state);
            ien_d      <= ien;
        end
    end

    // Next state / remain; a button edge takes priority over a same-cycle tick.
    always_comb begin
        state_n  = state;
        remain_n = remain;
        if (state == COL_OFF) begin
            if (ien_e) begin
                state_n  = COL_RED;
                remain_n = LEN_RED;
            end
        end else if (ien_e) begin
            if (!mode) begin
                state_n  = COL_OFF;
                remain_n = '0;
            end else begin
                state_n  = next_col(state);
                remain_n = load_of(next_col(state));
            end
        end else if (tick && !mode) begin
            if (remain != '0) begin
                remain_n = remain - CNT_W'(1);
            end else begin
                state_n  = next_col(state);
                remain_n = load_of(next_col(state));
            end
        end
        tick_clr = (state_n != state);
    end

    assign col = state;

endmodule

// File: tb/tb_tricol_seq.sv
// Self-checking bench for tricol_seq: directed scenarios plus randomized traffic,
// compared every cycle against a phase-level reference model.
module tb_tricol_seq;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned T_RED    = 3;
    localparam int unsigned T_GREEN  = 2;
    localparam int unsigned T_YELLOW = 1;
    localparam int unsigned CNT_W    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             ien;
    logic             mode;
    logic             hold;
    logic [1:0]       col;
    logic [CNT_W-1:0] remain;
    logic             phase_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0 idle, 1 red, 2 green, 3 yellow (same as colour code).
    int m_ph   = 0;
    int m_rem  = 0;
    int m_cnt  = 0;
    int m_pd   = 0;
    bit m_iend = 1'b0;
    int len_tab [4] = '{0, T_RED, T_GREEN, T_YELLOW};

    tricol_seq #(
        .TICK_DIV (TICK_DIV),
        .T_RED    (T_RED),
        .T_GREEN  (T_GREEN),
        .T_YELLOW (T_YELLOW),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ien        (ien),
        .mode       (mode),
        .hold       (hold),
        .col        (col),
        .remain     (remain),
        .phase_done (phase_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int succ(input int ph);
        return (ph % 3) + 1;
    endfunction

    // One clock of the model, using the inputs as sampled on the edge.
    task automatic model_step();
        bit e;
        bit tk;
        int old;
        if (rst) begin
            m_ph = 0; m_rem = 0; m_cnt = 0; m_pd = 0; m_iend = 1'b0;
        end else begin
            e      = ien && !m_iend;
            m_iend = ien;
            tk     = (m_ph != 0) && !hold && (m_cnt == TICK_DIV - 1);
            old    = m_ph;
            if (m_ph == 0) begin
                if (e) begin m_ph = 1; m_rem = T_RED - 1; end
            end else if (e) begin
                if (!mode) begin m_ph = 0; m_rem = 0; end
                else begin m_ph = succ(m_ph); m_rem = len_tab[m_ph] - 1; end
            end else if (tk && !mode) begin
                if (m_rem > 0) m_rem--;
                else begin m_ph = succ(m_ph); m_rem = len_tab[m_ph] - 1; end
            end
            if (m_ph != old)               m_cnt = 0;
            else if (old != 0 && !hold)    m_cnt = (m_cnt + 1) % TICK_DIV;
            m_pd = (m_ph != old) ? 1 : 0;
        end
    endtask

    // Drive one cycle, advance the model, and compare all outputs.
    task automatic cyc(input logic r, input logic i, input logic m, input logic h);
        rst = r; ien = i; mode = m; hold = h;
        @(posedge clk);
        model_step();
        #1;
        check("col", int'(col), m_ph);
        check("remain", int'(remain), m_rem);
        check("phase_done", int'(phase_done), m_pd);
    endtask

    task automatic run(input int n, input logic i, input logic m, input logic h);
        for (int k = 0; k < n; k++) cyc(1'b0, i, m, h);
    endtask

    initial begin
        rst = 1'b1; ien = 1'b0; mode = 1'b0; hold = 1'b0;

        // 1. reset with ien toggling
        for (int k = 0; k < 10; k++) cyc(1'b1, k[0], 1'b0, 1'b0);
        check("rst_col", int'(col), 0);

        // 2. auto start and full cycle
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("s2_red_col", int'(col), 1);
        check("s2_red_rem", int'(remain), 2);
        check("s2_red_pd", int'(phase_done), 1);
        run(12, 1'b1, 1'b0, 1'b0);
        check("s2_green_col", int'(col), 2);
        check("s2_green_rem", int'(remain), 1);
        run(8, 1'b1, 1'b0, 1'b0);
        check("s2_yellow_col", int'(col), 3);
        check("s2_yellow_rem", int'(remain), 0);
        run(4, 1'b1, 1'b0, 1'b0);
        check("s2_wrap_col", int'(col), 1);
        check("s2_wrap_pd", int'(phase_done), 1);

        // 3. hold in GREEN with remain=1
        run(12, 1'b1, 1'b0, 1'b0);
        check("s3_green", int'(col), 2);
        run(20, 1'b1, 1'b0, 1'b1);
        check("s3_hold_col", int'(col), 2);
        check("s3_hold_rem", int'(remain), 1);
        run(4, 1'b1, 1'b0, 1'b0);
        check("s3_rem0", int'(remain), 0);
        run(4, 1'b1, 1'b0, 1'b0);
        check("s3_yellow", int'(col), 3);

        // 4. manual stepping; held ien is a single event
        run(4, 1'b1, 1'b0, 1'b0);
        check("s4_red", int'(col), 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        run(10, 1'b1, 1'b1, 1'b0);
        check("s4_one_step", int'(col), 2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        check("s4_step_y", int'(col), 3);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        check("s4_step_r", int'(col), 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        check("s4_step_g", int'(col), 2);
        run(20, 1'b0, 1'b1, 1'b0);
        check("s4_tick_ign_col", int'(col), 2);
        check("s4_tick_ign_rem", int'(remain), 1);

        // 5. ien edge on the same cycle as the RED->GREEN tick
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        check("s5_red_entry", int'(col), 1);
        run(10, 1'b1, 1'b0, 1'b0);
        check("s5_rem0", int'(remain), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("s5_idle_col", int'(col), 0);
        check("s5_idle_pd", int'(phase_done), 1);

        // 6. reset mid-YELLOW then restart
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        run(20, 1'b1, 1'b0, 1'b0);
        check("s6_yellow", int'(col), 3);
        run(2, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("s6_rst_col", int'(col), 0);
        check("s6_rst_rem", int'(remain), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("s6_restart_col", int'(col), 1);
        check("s6_restart_rem", int'(remain), 2);

        // Randomized traffic against the model
        begin
            logic r_i, r_m, r_h, r_r;
            r_i = 1'b0; r_m = 1'b0;
            for (int k = 0; k < 3000; k++) begin
                if ($urandom_range(5, 0) == 0)  r_i = ~r_i;
                if ($urandom_range(49, 0) == 0) r_m = ~r_m;
                r_h = ($urandom_range(7, 0) == 0);
                r_r = ($urandom_range(199, 0) == 0);
                cyc(r_r, r_i, r_m, r_h);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
